adder_seq: RTL and testbench

- Multi-byte add/subtract sequencer that drives one shared 8-bit adder (a + b + cin → y, no carry-out) byte-serially, least significant byte first.
- Recovers the inter-byte carry from operand and result MSBs and chains it into the next byte.
- Sits between a requesting control unit (start/busy/done handshake) and the 8-bit adder datapath.

---
 rtl/adder_seq.sv | 108 ++++++++++
 tb/tb_adder_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq.sv
// Byte-serial multi-byte add/subtract sequencer driving one shared external 8-bit adder.
// Each RUN cycle adds one byte, least significant first, and rebuilds the carry from the operand and result MSBs.
module adder_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [8*NBYTES-1:0]   a_in,
    input  logic [8*NBYTES-1:0]   b_in,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_y
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state;
    logic [NBYTES-1:0][7:0]  a_reg;
    logic [NBYTES-1:0][7:0]  b_reg;
    logic [NBYTES-1:0][7:0]  sum_r;
    logic [IW-1:0]           idx;
    logic                    carry;
    logic                    new_carry;
    logic                    last_byte;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[idx];
            add_b   = b_reg[idx];
            add_cin = carry;
        end
    end

    // The adder has no carry-out, so derive it: both MSBs set, or one set and the result MSB cleared.
    assign new_carry = (add_a[7] & add_b[7]) | ((add_a[7] | add_b[7]) & ~add_y[7]);
    assign last_byte = (idx == IW'(NBYTES - 1));
    assign sum       = sum_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum_r <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= a_in;
                        b_reg <= sub ? ~b_in : b_in;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        sum_r <= '0;
                        cout  <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_r[idx] <= add_y;
                    carry      <= new_carry;
                    if (last_byte) begin
                        idx   <= '0;
                        cout  <= new_carry;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq.sv
// Directed bench for adder_seq with NBYTES=4 and a behavioural 8-bit adder on the add_* bus.
// Each scenario task drives its vectors and compares against hand-computed results.
module tb_adder_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic        cin;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        cout;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_y;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign add_y = add_a + add_b + {7'd0, add_cin};

    adder_seq #(.NBYTES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sub     (sub),
        .cin     (cin),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_cin (add_cin),
        .add_y   (add_y)
    );

    // Starts one operation from IDLE (called #1 after an edge) and returns what was observed;
    // lat counts edges after the accept edge until done is seen, busy_n counts busy samples.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, input logic c,
                                  output logic [31:0] res, output logic co,
                                  output int lat, output int busy_n,
                                  output logic first_cin, output int done_n);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        sub   = s;
        cin   = c;
        @(posedge clk);
        #1;
        start     = 1'b0;
        lat       = 0;
        busy_n    = busy ? 1 : 0;
        done_n    = done ? 1 : 0;
        first_cin = add_cin;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_n++;
            if (done) done_n++;
        end
        res = sum;
        co  = cout;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (busy) busy_n++;
            if (done) done_n++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (sum !== 32'h0)    begin errors++; $display("[TB] FAIL reset_sum: got %h expected 00000000", sum); end
        checks++; if (cout !== 1'b0)    begin errors++; $display("[TB] FAIL reset_cout: got %b expected 0", cout); end
        checks++; if (add_a !== 8'h0)   begin errors++; $display("[TB] FAIL reset_add_a: got %h expected 00", add_a); end
        checks++; if (add_b !== 8'h0)   begin errors++; $display("[TB] FAIL reset_add_b: got %h expected 00", add_b); end
        checks++; if (add_cin !== 1'b0) begin errors++; $display("[TB] FAIL reset_add_cin: got %b expected 0", add_cin); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_add_basic();
        logic [31:0] r; logic co; int lat; int bn; logic fc; int dn;
        apply_stimulus(32'h000000FF, 32'h00000001, 1'b0, 1'b0, r, co, lat, bn, fc, dn);
        checks++; if (r !== 32'h00000100) begin errors++; $display("[TB] FAIL add_ff_sum: got %h expected 00000100", r); end
        checks++; if (co !== 1'b0)        begin errors++; $display("[TB] FAIL add_ff_cout: got %b expected 0", co); end
        checks++; if (lat !== 4)          begin errors++; $display("[TB] FAIL add_ff_latency: got %0d expected 4", lat); end
        checks++; if (bn !== 5)           begin errors++; $display("[TB] FAIL add_ff_busy_cycles: got %0d expected 5", bn); end
        checks++; if (dn !== 1)           begin errors++; $display("[TB] FAIL add_ff_done_pulses: got %0d expected 1", dn); end
    endtask

    task automatic test_add_ripple();
        logic [31:0] r; logic co; int lat; int bn; logic fc; int dn;
        apply_stimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, r, co, lat, bn, fc, dn);
        checks++; if (r !== 32'h00000000) begin errors++; $display("[TB] FAIL ripple_sum: got %h expected 00000000", r); end
        checks++; if (co !== 1'b1)        begin errors++; $display("[TB] FAIL ripple_cout: got %b expected 1", co); end
        checks++; if (lat !== 4)          begin errors++; $display("[TB] FAIL ripple_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_add_cin();
        logic [31:0] r; logic co; int lat; int bn; logic fc; int dn;
        apply_stimulus(32'h12345678, 32'h11111111, 1'b0, 1'b1, r, co, lat, bn, fc, dn);
        checks++; if (r !== 32'h2345678A) begin errors++; $display("[TB] FAIL cin_sum: got %h expected 2345678a", r); end
        checks++; if (co !== 1'b0)        begin errors++; $display("[TB] FAIL cin_cout: got %b expected 0", co); end
        checks++; if (fc !== 1'b1)        begin errors++; $display("[TB] FAIL cin_first_add_cin: got %b expected 1", fc); end
    endtask

    task automatic test_subtract();
        logic [31:0] r; logic co; int lat; int bn; logic fc; int dn;
        apply_stimulus(32'h00000100, 32'h00000001, 1'b1, 1'b0, r, co, lat, bn, fc, dn);
        checks++; if (r !== 32'h000000FF) begin errors++; $display("[TB] FAIL sub_pos_sum: got %h expected 000000ff", r); end
        checks++; if (co !== 1'b1)        begin errors++; $display("[TB] FAIL sub_pos_cout: got %b expected 1", co); end
        checks++; if (fc !== 1'b1)        begin errors++; $display("[TB] FAIL sub_pos_first_cin: got %b expected 1", fc); end
        apply_stimulus(32'h00000000, 32'h00000001, 1'b1, 1'b1, r, co, lat, bn, fc, dn);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL sub_neg_sum: got %h expected ffffffff", r); end
        checks++; if (co !== 1'b0)        begin errors++; $display("[TB] FAIL sub_neg_cout: got %b expected 0", co); end
    endtask

    // start stays high throughout; operands change right after each accept.
    task automatic test_back_to_back();
        int done_n = 0;
        start = 1'b1;
        sub   = 1'b0;
        cin   = 1'b0;
        a_in  = 32'h00000010;
        b_in  = 32'h00000020;
        @(posedge clk);
        #1;
        a_in = 32'hAAAA0000;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            if (done) done_n++;
            if (k == 2) begin
                a_in = 32'h55550000;
                b_in = 32'h00000001;
            end
            if (k == 4) begin
                checks++; if (done !== 1'b1)      begin errors++; $display("[TB] FAIL b2b_done1: got %b expected 1", done); end
                checks++; if (sum !== 32'h00000030) begin errors++; $display("[TB] FAIL b2b_sum1: got %h expected 00000030", sum); end
                a_in = 32'hAAAA0000;
                b_in = 32'h00000020;
            end
            if (k == 5) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_gap: got %b expected 0", busy); end
                checks++; if (sum !== 32'h00000030) begin errors++; $display("[TB] FAIL b2b_sum_hold: got %h expected 00000030", sum); end
            end
            if (k == 6) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_reaccept: got %b expected 1", busy); end
            end
            if (k == 10) begin
                checks++; if (done !== 1'b1)        begin errors++; $display("[TB] FAIL b2b_done2: got %b expected 1", done); end
                checks++; if (sum !== 32'hAAAA0020) begin errors++; $display("[TB] FAIL b2b_sum2: got %h expected aaaa0020", sum); end
            end
        end
        start = 1'b0;
        checks++; if (done_n !== 2) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_n); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        logic [31:0] r; logic co; int lat; int bn; logic fc; int dn;
        int stray = 0;
        start = 1'b1;
        sub   = 1'b0;
        cin   = 1'b0;
        a_in  = 32'h01010101;
        b_in  = 32'h02020202;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
        checks++; if (sum !== 32'h0)    begin errors++; $display("[TB] FAIL abort_sum: got %h expected 00000000", sum); end
        checks++; if (cout !== 1'b0)    begin errors++; $display("[TB] FAIL abort_cout: got %b expected 0", cout); end
        checks++; if (add_a !== 8'h0 || add_b !== 8'h0 || add_cin !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_add_bus: got %h/%h/%b expected 00/00/0", add_a, add_b, add_cin);
        end
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL abort_stray_done: got %0d expected 0", stray); end
        apply_stimulus(32'h00000002, 32'h00000003, 1'b0, 1'b0, r, co, lat, bn, fc, dn);
        checks++; if (r !== 32'h00000005) begin errors++; $display("[TB] FAIL post_abort_sum: got %h expected 00000005", r); end
        checks++; if (co !== 1'b0)        begin errors++; $display("[TB] FAIL post_abort_cout: got %b expected 0", co); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_add_basic();
        test_add_ripple();
        test_add_cin();
        test_subtract();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
